// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_pkg
// Purpose  : Shared trellis/survivor-ring parameters, traceback FSM state type
//            and mod-D ring-pointer helper for the Viterbi decoder slice.
// Contents : K, M, S, D, TB, PTR_W, FILL_W, STEP_W, tb_state_t, ring_dec()
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    localparam int K      = 5;                 // constraint length
    localparam int M      = K - 1;             // state width
    localparam int S      = 1 << M;            // number of trellis states
    localparam int D      = 10;                // survivor ring depth (rows)
    localparam int TB     = 8;                 // traceback length (1..D-1)

    localparam int PTR_W  = $clog2(D);         // ring index width
    localparam int FILL_W = $clog2(D + 1);     // fill counter must hold D itself
    localparam int STEP_W = (TB > 1) ? $clog2(TB) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACE = 2'd1,
        DONE  = 2'd2
    } tb_state_t;

    // Step one row back around the ring. D need not be a power of two, so
    // the wrap from 0 to D-1 is explicit rather than relying on overflow.
    function automatic logic [PTR_W-1:0] ring_dec(input logic [PTR_W-1:0] ptr);
        return (ptr == '0) ? PTR_W'(D - 1) : ptr - PTR_W'(1);
    endfunction

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/traceback_unit.sv
`default_nettype none
// ============================================================================
// Module   : traceback_unit
// Purpose  : Serial traceback engine behind the survivor memory. On an
//            accepted start it walks TB rows backwards through the survivor
//            ring (one row per cycle) from the best-metric state and emits one
//            decoded bit.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start, start_state - traceback request and its starting state
//            wr_en, wr_ptr      - survivor write strobe / next row to write
//            rd_state, rd_time  - survivor memory combinational read address
//            surv_bit           - survivor bit returned for rd_state/rd_time
//            busy               - high while tracing
//            dec_valid, dec_bit - decoded-bit pulse and held decoded bit
//            start_drop         - pulse: a start request was rejected
// Revision : 1.0 - initial release
// ============================================================================
module traceback_unit
    import viterbi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [M-1:0]     start_state,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    output logic [M-1:0]     rd_state,
    output logic [PTR_W-1:0] rd_time,
    input  logic             surv_bit,
    output logic             busy,
    output logic             dec_valid,
    output logic             dec_bit,
    output logic             start_drop
);

    localparam logic [STEP_W-1:0] c_LAST_STEP = STEP_W'(TB - 1);
    localparam logic [FILL_W-1:0] c_FILL_MAX  = FILL_W'(D);
    localparam logic [FILL_W-1:0] c_FILL_MIN  = FILL_W'(TB);

    tb_state_t         state_q;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [STEP_W-1:0] step_q;
    logic [M-1:0]      cur_state_q;   // state being read this TRACE cycle
    logic [PTR_W-1:0]  rd_ptr_q;      // row being read this TRACE cycle
    logic              busy_q;
    logic              dec_valid_q;
    logic              dec_bit_q;
    logic              start_drop_q;
    logic              start_ok;

    // ------------------------------------------------------------------
    // Fill counter: rows written since reset, saturating at ring depth.
    // ------------------------------------------------------------------
    always_comb begin
        fill_d = fill_q;
        if (wr_en && (fill_q != c_FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // The pre-write fill count decides legality, matching the pre-write
    // wr_ptr sample: a row written in the start cycle is not traced.
    assign start_ok = (fill_q >= c_FILL_MIN);

    // ------------------------------------------------------------------
    // Traceback FSM with registered outputs.
    // cur_state_q / rd_ptr_q double as the read-port address registers.
    // They are not advanced on the final step so the read address holds
    // the last row visited once the walk ends.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= '0;
            cur_state_q  <= '0;
            rd_ptr_q     <= '0;
            busy_q       <= 1'b0;
            dec_valid_q  <= 1'b0;
            dec_bit_q    <= 1'b0;
            start_drop_q <= 1'b0;
        end else begin
            dec_valid_q  <= 1'b0;
            start_drop_q <= 1'b0;

            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start) begin
                        if (start_ok) begin
                            state_q     <= TRACE;
                            busy_q      <= 1'b1;
                            cur_state_q <= start_state;
                            rd_ptr_q    <= ring_dec(wr_ptr);
                            step_q      <= '0;
                        end else begin
                            start_drop_q <= 1'b1;
                        end
                    end
                end

                TRACE: begin
                    if (start) begin
                        start_drop_q <= 1'b1;
                    end
                    if (step_q == c_LAST_STEP) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        dec_valid_q <= 1'b1;
                        // The MSB of the predecessor {s[M-2:0], surv_bit} is
                        // s[M-2]; the survivor bit itself does not reach it.
                        dec_bit_q   <= cur_state_q[M-2];
                    end else begin
                        cur_state_q <= {cur_state_q[M-2:0], surv_bit};
                        rd_ptr_q    <= ring_dec(rd_ptr_q);
                        step_q      <= step_q + STEP_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_state   = cur_state_q;
    assign rd_time    = rd_ptr_q;
    assign busy       = busy_q;
    assign dec_valid  = dec_valid_q;
    assign dec_bit    = dec_bit_q;
    assign start_drop = start_drop_q;

endmodule : traceback_unit
`default_nettype wire
